fighter_player: RTL

FIGHTER_PLAYER -- requirements
Module: fighter_player

---
 rtl/fighter_player.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fighter_player.sv
// Single fighter on a 1-D board: movement, hits taken, regen and knockout.
// All rules are evaluated from pre-edge state; reset wins over everything.
module fighter_player #(
   parameter int NUM_POS     = 5,
   parameter int HP_W        = 2,
   parameter int REGEN_WAITS = 2,
   parameter int KICK_DMG    = 1,
   parameter int PUNCH_DMG   = 2,
   parameter int SIDE        = 0,
   localparam int PW         = $clog2(NUM_POS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          act_valid,
   input  logic [2:0]    my_action,
   input  logic [2:0]    opp_action,
   input  logic [PW-1:0] opp_pos,
   output logic [PW-1:0] pos,
   output logic [HP_W-1:0] health,
   output logic          hit,
   output logic          ko
);

   typedef enum logic [2:0] {
      A_KICK  = 3'b000,
      A_PUNCH = 3'b001,
      A_AWAIT = 3'b010,
      A_JUMP  = 3'b011,
      A_L1    = 3'b100,
      A_L2    = 3'b101,
      A_R1    = 3'b110,
      A_R2    = 3'b111
   } action_e;

   localparam int HP_MAX = (1 << HP_W) - 1;
   localparam int TDIR   = (SIDE == 0) ? 1 : -1;

   logic [PW-1:0]   pos_q, pos_d;
   logic [HP_W-1:0] health_q, health_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic            hit_q, hit_d;
   logic            ko_q, ko_d;

   int  p, o, h, d, s, t, lim, gap, dmg, wc;
   logic clash, punch_hit, kick_hit, opp_toward;

   always_comb begin
      pos_d    = pos_q;
      health_d = health_q;
      wcnt_d   = wcnt_q;
      hit_d    = 1'b0;
      ko_d     = ko_q;
      p   = int'(pos_q);
      o   = int'(opp_pos);
      h   = int'(health_q);
      d   = (p > o) ? (p - o) : (o - p);
      s   = 0;
      t   = p;
      lim = 0;
      dmg = 0;
      wc  = int'(wcnt_q) + 1;

      if (SIDE == 0)
         opp_toward = (opp_action == A_L1) || (opp_action == A_L2);
      else
         opp_toward = (opp_action == A_R1) || (opp_action == A_R2);
      gap = opp_toward ? 2 : 1;

      clash     = (d == 1) && (my_action == A_KICK) && (opp_action == A_KICK);
      punch_hit = (opp_action == A_PUNCH) && (d == 1);
      kick_hit  = (opp_action == A_KICK) && (d <= 2) &&
                  (my_action != A_JUMP) && !clash;

      unique case (my_action)
         A_L1:    s = -1;
         A_L2:    s = -2;
         A_R1:    s = 1;
         A_R2:    s = 2;
         default: s = 0;
      endcase
      // a landed punch or a kick clash replaces own movement with a push away
      if (punch_hit || clash) s = -TDIR;

      t = p + s;
      if (s * TDIR > 0) begin
         lim = o - TDIR * gap;
         if (SIDE == 0) begin
            if (t > lim) t = lim;
            if (t > NUM_POS - 1) t = NUM_POS - 1;
            if (t < p) t = p;
         end else begin
            if (t < lim) t = lim;
            if (t < 0) t = 0;
            if (t > p) t = p;
         end
      end else begin
         if (t < 0) t = 0;
         if (t > NUM_POS - 1) t = NUM_POS - 1;
      end

      if (punch_hit) dmg = PUNCH_DMG;
      else if (kick_hit) dmg = KICK_DMG;

      if (act_valid && !ko_q) begin
         pos_d = PW'(t);
         if (punch_hit || kick_hit) begin
            hit_d    = 1'b1;
            wcnt_d   = '0;
            health_d = (h > dmg) ? HP_W'(h - dmg) : '0;
            if (h <= dmg) ko_d = 1'b1;
         end else if (my_action == A_AWAIT) begin
            if (wc >= REGEN_WAITS) begin
               wcnt_d = '0;
               if (h < HP_MAX) health_d = HP_W'(h + 1);
            end else begin
               wcnt_d = 4'(wc);
            end
         end else begin
            wcnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q    <= (SIDE == 0) ? '0 : PW'(NUM_POS - 1);
         health_q <= HP_W'(HP_MAX);
         wcnt_q   <= '0;
         hit_q    <= 1'b0;
         ko_q     <= 1'b0;
      end else begin
         pos_q    <= pos_d;
         health_q <= health_d;
         wcnt_q   <= wcnt_d;
         hit_q    <= hit_d;
         ko_q     <= ko_d;
      end
   end

   assign pos    = pos_q;
   assign health = health_q;
   assign hit    = hit_q;
   assign ko     = ko_q;

endmodule
